// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32I decode stage: main/ALU decoders, immediate extend, ID/EX register
module id_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        FlushE,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCPlus4E
);

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        regwrite_d, alusrc_d, memwrite_d, branch_d, jump_d;
    logic [1:0]  immsrc_d, resultsrc_d, aluop_d;
    logic [2:0]  alucontrol_d;
    logic [31:0] immext_d;

    assign op       = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];

    always_comb begin
        {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b0;
        case (op)
            7'b0000011: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b1_00_1_0_01_0_00_0;
            7'b0100011: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b0_01_1_1_00_0_00_0;
            7'b0110011: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b1_00_0_0_00_0_10_0;
            7'b1100011: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b0_10_0_0_00_1_01_0;
            7'b0010011: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b1_00_1_0_00_0_10_0;
            7'b1101111: {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b1_11_0_0_10_0_00_1;
            default:    {regwrite_d, immsrc_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, aluop_d, jump_d} = 11'b0;
        endcase
    end

    // sub only for R-type; I-type with imm bit 30 set is still addi
    always_comb begin
        alucontrol_d = 3'b000;
        case (aluop_d)
            2'b00: alucontrol_d = 3'b000;
            2'b01: alucontrol_d = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol_d = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol_d = 3'b101;
                    3'b110:  alucontrol_d = 3'b011;
                    3'b111:  alucontrol_d = 3'b010;
                    default: alucontrol_d = 3'b000;
                endcase
            end
            default: alucontrol_d = 3'b000;
        endcase
    end

    always_comb begin
        immext_d = 32'b0;
        case (immsrc_d)
            2'b00: immext_d = {{20{InstrD[31]}}, InstrD[31:20]};
            2'b01: immext_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10: immext_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            2'b11: immext_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immext_d = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b0;
            ALUControlE <= 3'b0;
            RdE         <= 5'b0;
            PCE         <= 32'b0;
            RD1E        <= 32'b0;
            RD2E        <= 32'b0;
            ImmExtE     <= 32'b0;
            PCPlus4E    <= 32'b0;
        end else begin
            RegWriteE   <= regwrite_d;
            MemWriteE   <= memwrite_d;
            JumpE       <= jump_d;
            BranchE     <= branch_d;
            ALUSrcE     <= alusrc_d;
            ResultSrcE  <= resultsrc_d;
            ALUControlE <= alucontrol_d;
            RdE         <= InstrD[11:7];
            PCE         <= PCD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= immext_d;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - directed scoreboard bench for id_decode_stage
module tb_id_decode_stage;

    typedef struct packed {
        logic        regwrite;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic        alusrc;
        logic [1:0]  resultsrc;
        logic [2:0]  aluctrl;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pcplus4;
    } eout_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        FlushE;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] PCE, RD1E, RD2E, ImmExtE, PCPlus4E;

    eout_t obs;
    eout_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .reset(reset), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
        .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E)
    );

    assign obs = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                  RdE, PCE, RD1E, RD2E, ImmExtE, PCPlus4E};

    task automatic check_now(input string tag, input eout_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ctrl = {regwrite,memwrite,jump,branch,alusrc,resultsrc[1:0],aluctrl[2:0]}
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic flush,
                        input logic [9:0] ctrl, input logic [4:0] rd, input logic [31:0] imm);
        eout_t e;
        @(negedge clk);
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; RD1D = rd1; RD2D = rd2; FlushE = flush;
        if (flush) e = '0;
        else e = {ctrl, rd, pc, rd1, rd2, imm, pc + 32'd4};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            check_now(tag, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b0; FlushE = 1'b0;
        InstrD = 32'h0080A283; PCD = 32'h40; PCPlus4D = 32'h44; RD1D = 32'h100; RD2D = 32'h55;
        #2;
        check_now("reset_state", '0);
        @(posedge clk);
        #1;
        check_now("reset_held_over_edge", '0);
        @(negedge clk);
        reset = 1'b1;

        step("lw",        32'h0080A283, 32'h40, 32'h100,      32'h55,       1'b0, 10'b10001_01_000, 5'd5,  32'h00000008);
        step("sw",        32'hFE612E23, 32'h44, 32'h200,      32'hABCD,     1'b0, 10'b01001_00_000, 5'd28, 32'hFFFFFFFC);
        step("sub",       32'h405201B3, 32'h48, 32'h7,        32'h3,        1'b0, 10'b10000_00_001, 5'd3,  32'h00000405);
        step("add",       32'h005201B3, 32'h4C, 32'h7,        32'h3,        1'b0, 10'b10000_00_000, 5'd3,  32'h00000005);
        step("jal",       32'h010000EF, 32'h20, 32'h1,        32'h2,        1'b0, 10'b10100_10_000, 5'd1,  32'h00000010);
        step("beq",       32'hFE000EE3, 32'h50, 32'h0,        32'h0,        1'b0, 10'b00010_00_001, 5'd29, 32'hFFFFFFFC);
        step("flush",     32'hFE000EE3, 32'h54, 32'h9,        32'h9,        1'b1, 10'b0,            5'd0,  32'h0);
        step("addi",      32'h00A00093, 32'h58, 32'h11,       32'h22,       1'b0, 10'b10001_00_000, 5'd1,  32'h0000000A);
        step("slti",      32'h00A02093, 32'h5C, 32'h11,       32'h22,       1'b0, 10'b10001_00_101, 5'd1,  32'h0000000A);
        step("ori",       32'h00A06093, 32'h60, 32'h11,       32'h22,       1'b0, 10'b10001_00_011, 5'd1,  32'h0000000A);
        step("andi",      32'h00A07093, 32'h64, 32'h11,       32'h22,       1'b0, 10'b10001_00_010, 5'd1,  32'h0000000A);
        step("slli_f3",   32'h00101093, 32'h68, 32'h11,       32'h22,       1'b0, 10'b10001_00_000, 5'd1,  32'h00000001);
        step("addi_b30",  32'hC0000093, 32'h6C, 32'h11,       32'h22,       1'b0, 10'b10001_00_000, 5'd1,  32'hFFFFFC00);
        step("and_r",     32'h0062F3B3, 32'h70, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 10'b10000_00_010, 5'd7,  32'h00000006);
        step("undef_7f",  32'h0000007F, 32'h74, 32'h33,       32'h44,       1'b0, 10'b00000_00_000, 5'd0,  32'h00000000);
        step("undef_ff",  32'hFFFFFFFF, 32'h78, 32'h33,       32'h44,       1'b0, 10'b00000_00_000, 5'd31, 32'hFFFFFFFF);

        step("pre_reset", 32'h010000EF, 32'h80, 32'hDEAD,     32'hBEEF,     1'b0, 10'b10100_10_000, 5'd1,  32'h00000010);
        #2;
        reset = 1'b0;
        FlushE = 1'b0;
        #1;
        check_now("async_reset_midcycle", '0);
        @(posedge clk);
        #1;
        check_now("reset_during_edge", '0);
        @(negedge clk);
        reset = 1'b1;
        step("post_reset_lw", 32'h0080A283, 32'h90, 32'h100, 32'h5, 1'b0, 10'b10001_01_000, 5'd5, 32'h00000008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
